scanner_code_filter: RTL and testbench



---
 rtl/scanner_code_filter_pkg.sv | 27 ++
 rtl/scanner_code_filter_checksum.sv | 52 +++++
 rtl/scanner_code_filter.sv | 149 ++++++++++++++
 tb/tb_scanner_code_filter.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scanner_code_filter_pkg.sv
// Shared constants, FSM encoding and checksum helpers for the EAN-13 read filter.
package scanner_code_filter_pkg;

  localparam int unsigned EanDigits  = 13;
  localparam int unsigned EanDigitW  = 4;
  localparam int unsigned EanCodeW   = EanDigits * EanDigitW;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StCheck = 2'd1,
    StVote  = 2'd2,
    StEval  = 2'd3
  } filterState_e;

  // Adds one weighted digit into a mod-10 accumulator.
  function automatic logic [3:0] mod10Add(input logic [3:0] acc, input logic [3:0] digit,
                                          input logic triple);
    logic [5:0] sum;
    sum = {2'b00, acc} + (triple ? ({2'b00, digit} * 6'd3) : {2'b00, digit});
    return 4'(sum % 6'd10);
  endfunction

  function automatic logic [3:0] checkDigit(input logic [3:0] acc);
    return (acc == 4'd0) ? 4'd0 : (4'd10 - acc);
  endfunction

endpackage

// File: rtl/scanner_code_filter_checksum.sv
// Serial EAN-13 checksum: one digit per cycle, 13 cycles after start.
module ean13ChecksumSerial
  import scanner_code_filter_pkg::*;
(
  input  logic                iClk,
  input  logic                iRst_neg,
  input  logic                iStart,
  input  logic [EanCodeW-1:0] iCode,
  output logic                oDone,
  output logic                oValid
);

  logic                busy_q;
  logic [3:0]          idx_q;
  logic [3:0]          acc_q;
  logic                bcdOk_q;
  logic [EanCodeW-1:0] shift_q;
  logic [3:0]          digit;

  assign digit = shift_q[EanCodeW-1 -: EanDigitW];
  // High during the cycle that consumes the check digit.
  assign oDone = busy_q && (idx_q == 4'(EanDigits - 1));

  always_ff @(posedge iClk) begin
    if (!iRst_neg) begin
      busy_q  <= 1'b0;
      idx_q   <= 4'd0;
      acc_q   <= 4'd0;
      bcdOk_q <= 1'b1;
      shift_q <= '0;
      oValid  <= 1'b0;
    end else if (iStart) begin
      busy_q  <= 1'b1;
      idx_q   <= 4'd0;
      acc_q   <= 4'd0;
      bcdOk_q <= 1'b1;
      shift_q <= iCode;
      oValid  <= 1'b0;
    end else if (busy_q) begin
      shift_q <= shift_q << EanDigitW;
      idx_q   <= idx_q + 4'd1;
      if (oDone) begin
        busy_q <= 1'b0;
        oValid <= bcdOk_q && (digit <= 4'd9) && (checkDigit(acc_q) == digit);
      end else begin
        acc_q   <= mod10Add(acc_q, digit, idx_q[0]);
        bcdOk_q <= bcdOk_q && (digit <= 4'd9);
      end
    end
  end

endmodule

// File: rtl/scanner_code_filter.sv
// Validates EAN-13 reads, votes them per frame and emits each confirmed code once while in view.
module scanner_code_filter
  import scanner_code_filter_pkg::*;
#(
  parameter int unsigned VPIXEL_W    = 11,
  parameter int unsigned MIN_HITS    = 3,
  parameter int unsigned HOLD_FRAMES = 30
) (
  input  logic                iClk,
  input  logic                iRst_neg,
  input  logic                iPixelSync,
  input  logic                iNewData,
  input  logic [EanCodeW-1:0] iDataCode,
  input  logic [VPIXEL_W-1:0] iVpixel,
  input  logic                iFifoFull,
  output logic                oNewData,
  output logic [EanCodeW-1:0] oDataCode,
  output logic [VPIXEL_W-1:0] oVpixel,
  output logic [7:0]          oBadCount,
  output logic [7:0]          oDropCount,
  output logic                oOverflow
);

  localparam int unsigned HoldW = $clog2(HOLD_FRAMES + 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(HOLD_FRAMES);

  filterState_e        state_q;
  logic                frameEndPending_q;
  logic [EanCodeW-1:0] readCode_q;
  logic [VPIXEL_W-1:0] readVp_q;
  logic [EanCodeW-1:0] cand_q;
  logic [VPIXEL_W-1:0] candVp_q;
  logic                candValid_q;
  logic [3:0]          hits_q;
  logic [3:0]          misses_q;
  logic [EanCodeW-1:0] last_q;
  logic                lastValid_q;
  logic [HoldW-1:0]    holdCnt_q;

  logic ckStart;
  logic ckDone;
  logic ckValid;
  logic confirmed;
  logic suppress;

  assign ckStart   = (state_q == StIdle) && iNewData;
  assign confirmed = candValid_q && (32'(hits_q) >= MIN_HITS) && (hits_q > misses_q);
  // Same code still in view: re-confirmation only refreshes the hold window.
  assign suppress  = lastValid_q && (cand_q == last_q) && (holdCnt_q < HoldMax);

  ean13ChecksumSerial u_checksum (
    .iClk     (iClk),
    .iRst_neg (iRst_neg),
    .iStart   (ckStart),
    .iCode    (iDataCode),
    .oDone    (ckDone),
    .oValid   (ckValid)
  );

  always_ff @(posedge iClk) begin
    if (!iRst_neg) begin
      state_q           <= StIdle;
      frameEndPending_q <= 1'b0;
      readCode_q        <= '0;
      readVp_q          <= '0;
      cand_q            <= '0;
      candVp_q          <= '0;
      candValid_q       <= 1'b0;
      hits_q            <= 4'd0;
      misses_q          <= 4'd0;
      last_q            <= '0;
      lastValid_q       <= 1'b0;
      holdCnt_q         <= HoldMax;
      oNewData          <= 1'b0;
      oDataCode         <= '0;
      oVpixel           <= '0;
      oBadCount         <= 8'd0;
      oDropCount        <= 8'd0;
      oOverflow         <= 1'b0;
    end else begin
      oNewData <= 1'b0;

      if (iNewData && (state_q != StIdle) && (oDropCount != 8'hFF)) begin
        oDropCount <= oDropCount + 8'd1;
      end

      case (state_q)
        StIdle: begin
          if (iNewData) begin
            readCode_q        <= iDataCode;
            readVp_q          <= iVpixel;
            frameEndPending_q <= iPixelSync;
            state_q           <= StCheck;
          end else if (iPixelSync) begin
            state_q <= StEval;
          end
        end

        StCheck: begin
          if (iPixelSync) frameEndPending_q <= 1'b1;
          if (ckDone) state_q <= StVote;
        end

        StVote: begin
          if (!ckValid) begin
            if (oBadCount != 8'hFF) oBadCount <= oBadCount + 8'd1;
          end else if (!candValid_q) begin
            candValid_q <= 1'b1;
            cand_q      <= readCode_q;
            candVp_q    <= readVp_q;
            hits_q      <= 4'd1;
          end else if (readCode_q == cand_q) begin
            if (hits_q != 4'hF) hits_q <= hits_q + 4'd1;
          end else if (misses_q != 4'hF) begin
            misses_q <= misses_q + 4'd1;
          end
          frameEndPending_q <= 1'b0;
          state_q           <= (frameEndPending_q || iPixelSync) ? StEval : StIdle;
        end

        StEval: begin
          if (confirmed && suppress) begin
            holdCnt_q <= '0;
          end else if (confirmed) begin
            last_q      <= cand_q;
            lastValid_q <= 1'b1;
            holdCnt_q   <= '0;
            if (iFifoFull) begin
              oOverflow <= 1'b1;
            end else begin
              oNewData  <= 1'b1;
              oDataCode <= cand_q;
              oVpixel   <= candVp_q;
            end
          end else if (holdCnt_q != HoldMax) begin
            holdCnt_q <= holdCnt_q + HoldW'(1);
          end
          candValid_q <= 1'b0;
          hits_q      <= 4'd0;
          misses_q    <= 4'd0;
          state_q     <= StIdle;
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_scanner_code_filter.sv
// Directed and randomized checks of scanner_code_filter against a frame-level reference model.
module tb_scanner_code_filter;

  localparam int unsigned VpW      = 11;
  localparam int          MinHits  = 3;
  localparam int          HoldMax  = 30;
  localparam logic [51:0] GoodCode = 52'h4006381333931;

  logic          clk = 1'b0;
  logic          rstN;
  logic          pixelSync;
  logic          newData;
  logic [51:0]   dataCode;
  logic [VpW-1:0] vpixel;
  logic          fifoFull;
  logic          outNewData;
  logic [51:0]   outDataCode;
  logic [VpW-1:0] outVpixel;
  logic [7:0]    badCount;
  logic [7:0]    dropCount;
  logic          overflow;

  int nChecks = 0;
  int nPass   = 0;
  int emitSeen = 0;

  // Reference model state
  logic [51:0]    mCodes[$];
  logic [VpW-1:0] mVps[$];
  logic [51:0]    mLast;
  bit             mLastValid;
  int             mHold;
  int             mBad;
  int             mDrop;
  bit             mOverflow;

  always #5 clk = ~clk;

  scanner_code_filter #(
    .VPIXEL_W    (VpW),
    .MIN_HITS    (MinHits),
    .HOLD_FRAMES (HoldMax)
  ) dut (
    .iClk       (clk),
    .iRst_neg   (rstN),
    .iPixelSync (pixelSync),
    .iNewData   (newData),
    .iDataCode  (dataCode),
    .iVpixel    (vpixel),
    .iFifoFull  (fifoFull),
    .oNewData   (outNewData),
    .oDataCode  (outDataCode),
    .oVpixel    (outVpixel),
    .oBadCount  (badCount),
    .oDropCount (dropCount),
    .oOverflow  (overflow)
  );

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic bit refValid(input logic [51:0] c);
    int s;
    int d;
    s = 0;
    for (int i = 0; i < 13; i++) begin
      d = int'(c[(12 - i) * 4 +: 4]);
      if (d > 9) return 1'b0;
      if (i < 12) s += d * (((i % 2) == 1) ? 3 : 1);
    end
    return ((10 - (s % 10)) % 10) == int'(c[3:0]);
  endfunction

  function automatic logic [51:0] makeValid();
    logic [51:0] c;
    int s;
    int d;
    c = '0;
    s = 0;
    for (int i = 0; i < 12; i++) begin
      d = int'($urandom_range(0, 9));
      c[(12 - i) * 4 +: 4] = 4'(d);
      s += d * (((i % 2) == 1) ? 3 : 1);
    end
    c[3:0] = 4'((10 - (s % 10)) % 10);
    return c;
  endfunction

  function automatic logic [51:0] corruptCheck(input logic [51:0] c);
    logic [51:0] r;
    r = c;
    r[3:0] = 4'((int'(c[3:0]) + int'($urandom_range(1, 9))) % 10);
    return r;
  endfunction

  function automatic logic [51:0] corruptBcd(input logic [51:0] c);
    logic [51:0] r;
    int pos;
    r = c;
    pos = int'($urandom_range(0, 12));
    r[pos * 4 +: 4] = 4'($urandom_range(10, 15));
    return r;
  endfunction

  task automatic modelReset();
    mCodes.delete();
    mVps.delete();
    mLast      = '0;
    mLastValid = 1'b0;
    mHold      = HoldMax;
    mBad       = 0;
    mDrop      = 0;
    mOverflow  = 1'b0;
  endtask

  task automatic modelRead(input logic [51:0] code, input logic [VpW-1:0] vp);
    if (refValid(code)) begin
      mCodes.push_back(code);
      mVps.push_back(vp);
    end else if (mBad < 255) begin
      mBad++;
    end
  endtask

  task automatic modelClose(input bit full, output bit emit, output logic [51:0] code,
                            output logic [VpW-1:0] vp);
    int hits;
    int misses;
    bit conf;
    emit   = 1'b0;
    code   = '0;
    vp     = '0;
    hits   = 0;
    misses = 0;
    foreach (mCodes[i]) begin
      if (mCodes[i] == mCodes[0]) hits++;
      else misses++;
    end
    if (hits > 15) hits = 15;
    if (misses > 15) misses = 15;
    conf = (mCodes.size() > 0) && (hits >= MinHits) && (hits > misses);
    if (conf) begin
      if (mLastValid && (mCodes[0] == mLast) && (mHold < HoldMax)) begin
        mHold = 0;
      end else begin
        mLast      = mCodes[0];
        mLastValid = 1'b1;
        mHold      = 0;
        if (full) mOverflow = 1'b1;
        else begin
          emit = 1'b1;
          code = mCodes[0];
          vp   = mVps[0];
        end
      end
    end else if (mHold < HoldMax) begin
      mHold++;
    end
    mCodes.delete();
    mVps.delete();
  endtask

  task automatic checkOutputs(input string tag, input bit expEmit, input logic [51:0] expCode,
                              input logic [VpW-1:0] expVp);
    checkVal({tag, " newData"}, 64'(outNewData), 64'(expEmit));
    if (outNewData) emitSeen++;
    if (expEmit) begin
      checkVal({tag, " code"}, 64'(outDataCode), 64'(expCode));
      checkVal({tag, " vpixel"}, 64'(outVpixel), 64'(expVp));
    end
    checkVal({tag, " badCount"}, 64'(badCount), 64'(mBad));
    checkVal({tag, " dropCount"}, 64'(dropCount), 64'(mDrop));
    checkVal({tag, " overflow"}, 64'(overflow), 64'(mOverflow));
    @(negedge clk);
    checkVal({tag, " newData pulse"}, 64'(outNewData), 64'd0);
  endtask

  task automatic doReset();
    @(negedge clk);
    rstN = 1'b0;
    pixelSync = 1'b0;
    newData = 1'b0;
    fifoFull = 1'b0;
    dataCode = '0;
    vpixel = '0;
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    modelReset();
  endtask

  // pokeKind: 0 none, 1 extra read while busy, 2 sync while busy, 3 sync with the read
  task automatic sendRead(input string tag, input logic [51:0] code, input logic [VpW-1:0] vp,
                          input int pokeAt, input int pokeKind);
    bit expEmit;
    logic [51:0] expCode;
    logic [VpW-1:0] expVp;
    @(negedge clk);
    newData   = 1'b1;
    dataCode  = code;
    vpixel    = vp;
    pixelSync = (pokeKind == 3);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      newData   = 1'b0;
      pixelSync = 1'b0;
      if (k == pokeAt && pokeKind == 1) begin
        newData  = 1'b1;
        dataCode = {20'h0, 32'($urandom)};
      end else if (k == pokeAt && pokeKind == 2) begin
        pixelSync = 1'b1;
      end
    end
    modelRead(code, vp);
    if (pokeKind == 1 && pokeAt >= 1 && pokeAt <= 14 && mDrop < 255) mDrop++;
    if (pokeKind >= 2) begin
      modelClose(1'b0, expEmit, expCode, expVp);
      @(negedge clk);
      checkOutputs(tag, expEmit, expCode, expVp);
    end
  endtask

  task automatic closeFrame(input string tag, input bit full);
    bit expEmit;
    logic [51:0] expCode;
    logic [VpW-1:0] expVp;
    @(negedge clk);
    pixelSync = 1'b1;
    fifoFull  = full;
    @(negedge clk);
    pixelSync = 1'b0;
    @(negedge clk);
    fifoFull = 1'b0;
    modelClose(full, expEmit, expCode, expVp);
    checkOutputs(tag, expEmit, expCode, expVp);
  endtask

  initial begin
    logic [51:0] codeX;
    logic [51:0] codeY;
    logic [51:0] pool[4];
    logic [51:0] pick;
    int n;
    int kind;

    rstN = 1'b0;
    doReset();
    @(negedge clk);
    checkVal("reset newData", 64'(outNewData), 64'd0);
    checkVal("reset code", 64'(outDataCode), 64'd0);
    checkVal("reset vpixel", 64'(outVpixel), 64'd0);
    checkVal("reset badCount", 64'(badCount), 64'd0);
    checkVal("reset dropCount", 64'(dropCount), 64'd0);
    checkVal("reset overflow", 64'(overflow), 64'd0);

    // Known-good code three times in one frame
    sendRead("t1", GoodCode, 11'd100, 0, 0);
    sendRead("t1", GoodCode, 11'd101, 0, 0);
    sendRead("t1", GoodCode, 11'd102, 0, 0);
    closeFrame("t1 close", 1'b0);
    checkVal("t1 known code", 64'(outDataCode), 64'(GoodCode));
    checkVal("t1 first line", 64'(outVpixel), 64'd100);

    // Same code in 40 frames, then 31 empty frames, then once more
    doReset();
    emitSeen = 0;
    for (int f = 0; f < 40; f++) begin
      for (int r = 0; r < 3; r++) sendRead("hold", GoodCode, VpW'(f * 3 + r), 0, 0);
      closeFrame("hold close", 1'b0);
    end
    checkVal("hold single emit", 64'(emitSeen), 64'd1);
    for (int f = 0; f < 31; f++) closeFrame("hold empty", 1'b0);
    for (int r = 0; r < 3; r++) sendRead("rearm", GoodCode, VpW'(500 + r), 0, 0);
    closeFrame("rearm close", 1'b0);
    checkVal("rearm emit total", 64'(emitSeen), 64'd2);

    // Bad checksum and non-BCD digit
    doReset();
    for (int r = 0; r < 5; r++) sendRead("bad", 52'h4006381333930, VpW'(r), 0, 0);
    sendRead("bad", 52'h4006381A33931, 11'd9, 0, 0);
    closeFrame("bad close", 1'b0);
    checkVal("bad count six", 64'(badCount), 64'd6);

    // Drop while busy, then frame close during CHECK of an in-flight read
    doReset();
    sendRead("drop", GoodCode, 11'd20, 0, 0);
    sendRead("drop", GoodCode, 11'd21, 5, 1);
    checkVal("drop count one", 64'(dropCount), 64'd1);
    sendRead("pending", GoodCode, 11'd22, 4, 2);
    checkVal("pending emit line", 64'(outVpixel), 64'd20);

    // Sync in the same idle cycle as a read
    doReset();
    sendRead("same", GoodCode, 11'd30, 0, 0);
    sendRead("same", GoodCode, 11'd31, 0, 0);
    sendRead("same", GoodCode, 11'd32, 0, 3);

    // Vote contest
    doReset();
    codeX = makeValid();
    codeY = makeValid();
    if (codeY == codeX) codeY = corruptCheck(codeX) ^ 52'h1;
    if (!refValid(codeY)) codeY = GoodCode;
    for (int r = 0; r < 3; r++) sendRead("tie", codeX, VpW'(r), 0, 0);
    for (int r = 0; r < 3; r++) sendRead("tie", codeY, VpW'(10 + r), 0, 0);
    closeFrame("tie close", 1'b0);
    for (int r = 0; r < 4; r++) sendRead("win", codeX, VpW'(40 + r), 0, 0);
    sendRead("win", codeY, 11'd50, 0, 0);
    closeFrame("win close", 1'b0);

    // Overflow is sticky until reset, including reset during CHECK
    doReset();
    for (int r = 0; r < 3; r++) sendRead("ovf", GoodCode, VpW'(r), 0, 0);
    closeFrame("ovf close", 1'b1);
    repeat (5) @(negedge clk);
    checkVal("ovf sticky", 64'(overflow), 64'd1);
    @(negedge clk);
    newData  = 1'b1;
    dataCode = GoodCode;
    @(negedge clk);
    newData = 1'b0;
    repeat (3) @(negedge clk);
    doReset();
    @(negedge clk);
    checkVal("ovf cleared", 64'(overflow), 64'd0);
    for (int r = 0; r < 3; r++) sendRead("post reset", GoodCode, VpW'(60 + r), 0, 0);
    closeFrame("post reset close", 1'b0);

    // Randomized frames
    doReset();
    pool[0] = makeValid();
    pool[1] = makeValid();
    for (int f = 0; f < 50; f++) begin
      n = int'($urandom_range(0, 5));
      for (int r = 0; r < n; r++) begin
        kind = int'($urandom_range(0, 9));
        pool[2] = corruptCheck(pool[0]);
        pool[3] = corruptBcd(pool[1]);
        pick = (kind < 4) ? pool[0] : (kind < 7) ? pool[1] : (kind < 9) ? pool[2] : pool[3];
        if (r == n - 1 && $urandom_range(0, 3) == 0) begin
          if ($urandom_range(0, 1) == 0)
            sendRead("rnd pend", pick, VpW'($urandom_range(0, 2047)),
                     int'($urandom_range(1, 14)), 2);
          else
            sendRead("rnd same", pick, VpW'($urandom_range(0, 2047)), 0, 3);
        end else begin
          sendRead("rnd", pick, VpW'($urandom_range(0, 2047)),
                   int'($urandom_range(1, 13)), ($urandom_range(0, 5) == 0) ? 1 : 0);
        end
      end
      if (n == 0 || mCodes.size() > 0 || $urandom_range(0, 1) == 0)
        closeFrame("rnd close", $urandom_range(0, 7) == 0);
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
